// File: rtl/timer_irq_src.sv
// ---------------------------------------------------------------------------
// timer_irq_src
//   Memory-mapped down-counting timer. It is the source of one CPU hardware
//   interrupt line. Software sets an enable bit, a mode, an interrupt mask and
//   a preset count over a small word-addressed register bus.
//     one-shot    : on expiry irq is raised and held until the next bus write
//                   to CTRL or PRESET. EN is cleared automatically.
//     auto-reload : on expiry irq pulses for one cycle and the count reloads.
//
// Ports
//   clk   in   1   clock, all state updates on posedge
//   rst   in   1   synchronous active-high reset
//   addr  in   2   word select: 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved
//   we    in   1   write strobe
//   din   in  32   write data
//   dout  out 32   read data, combinational on addr (zero-extended)
//   irq   out  1   interrupt request (irq_flag AND IM, both registered)
//
// CTRL layout: [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot),
//              [3] IM. All other bits read as 0.
// ---------------------------------------------------------------------------
module timer_irq_src #(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t             state_reg;
    logic               ctrl_en_reg;
    logic [1:0]         ctrl_mode_reg;
    logic               ctrl_im_reg;
    logic [CNT_W-1:0]   preset_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               irq_flag_reg;

    logic               wr_ctrl;
    logic               wr_preset;
    logic               en_next;
    logic [1:0]         mode_next;

    assign wr_ctrl   = we && (addr == 2'd0);
    assign wr_preset = we && (addr == 2'd1);

    // The FSM sees CTRL as it will be after this edge, so a write that sets EN
    // starts the timer at the same edge and a write that clears EN stops it.
    assign en_next   = wr_ctrl ? din[0]   : ctrl_en_reg;
    assign mode_next = wr_ctrl ? din[2:1] : ctrl_mode_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ctrl_en_reg   <= 1'b0;
            ctrl_mode_reg <= 2'b00;
            ctrl_im_reg   <= 1'b0;
            preset_reg    <= PRESET_RST;
            count_reg     <= '0;
            irq_flag_reg  <= 1'b0;
        end else begin
            if (wr_preset) begin
                // New preset: park in IDLE with COUNT untouched; if EN is still
                // set the next edge goes to LOAD and restarts from the new value.
                preset_reg   <= CNT_W'(din);
                state_reg    <= ST_IDLE;
                irq_flag_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (en_next) begin
                            state_reg <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        count_reg <= preset_reg;
                        state_reg <= ST_CNT;
                    end
                    ST_CNT: begin
                        if (!en_next) begin
                            state_reg <= ST_IDLE;
                        end else if (count_reg > CNT_W'(1)) begin
                            count_reg <= count_reg - CNT_W'(1);
                        end else begin
                            // Covers COUNT==0 too, so PRESET=0 acts like 1
                            // and COUNT never wraps.
                            count_reg    <= '0;
                            irq_flag_reg <= 1'b1;
                            state_reg    <= ST_INT;
                        end
                    end
                    ST_INT: begin
                        if (mode_next == MODE_RELOAD) begin
                            irq_flag_reg <= 1'b0;
                            state_reg    <= ST_LOAD;
                        end else begin
                            ctrl_en_reg <= 1'b0;
                            state_reg   <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end

            // Placed after the FSM so a software write overrides both the
            // automatic EN clear and a same-edge irq_flag set.
            if (wr_ctrl) begin
                ctrl_en_reg   <= din[0];
                ctrl_mode_reg <= din[2:1];
                ctrl_im_reg   <= din[3];
                irq_flag_reg  <= 1'b0;
            end
        end
    end

    // Both operands are registers: no combinational bus-to-irq path.
    assign irq = irq_flag_reg & ctrl_im_reg;

    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd0:    dout = {28'd0, ctrl_im_reg, ctrl_mode_reg, ctrl_en_reg};
            2'd1:    dout = 32'(preset_reg);
            2'd2:    dout = 32'(count_reg);
            default: dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_irq_src.sv
module tb_timer_irq_src;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_irq_src #(
        .CNT_W      (32),
        .PRESET_RST (32'd0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus write taking effect at the next edge; returns 1ns after it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        $display("wr addr=%0d data=0x%08h irq=%0b", a, d, irq);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%0b exp=0", irq);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctrl got=0x%08h exp=0x0", d);
        end
        rd(2'd1, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_preset got=0x%08h exp=0x0", d);
        end
        rd(2'd2, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_count got=0x%08h exp=0x0", d);
        end
        $display("test_reset done");
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);                  // edge T
        for (int k = 1; k <= 6; k++) begin
            tick();                        // after edge T+k
            rd(2'd2, d);
            checks++;
            if (d !== 32'(6 - k)) begin
                errors++;
                $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, d, 6 - k);
            end
            checks++;
            if (irq !== (k == 6)) begin
                errors++;
                $display("FAIL oneshot_irq k=%0d got=%0b exp=%0b", k, irq, (k == 6));
            end
        end
        tick();
        rd(2'd0, d);
        checks++;
        if (d !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_ctrl_en_cleared got=0x%08h exp=0x8", d);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (irq !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_irq_held got=%0b exp=1", irq);
            end
        end
        wr(2'd0, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_clear got=%0b exp=0", irq);
        end
        $display("test_one_shot done");
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic        exp_irq;
        int          p;
        int          exp_cnt;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);                  // edge T
        for (int k = 1; k <= 50; k++) begin
            tick();
            rd(2'd2, d);
            exp_irq = (k >= 4) && (((k - 4) % 5) == 0);
            p       = (k - 1) % 5;
            exp_cnt = (p < 3) ? (3 - p) : 0;
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL reload_irq k=%0d got=%0b exp=%0b", k, irq, exp_irq);
            end
            checks++;
            if (d !== 32'(exp_cnt)) begin
                errors++;
                $display("FAIL reload_count k=%0d got=%0d exp=%0d", k, d, exp_cnt);
            end
        end
        wr(2'd0, 32'h0);
        $display("test_auto_reload done");
    endtask

    task automatic test_mask_pause();
        logic [31:0] d;
        // IM=0: flag fires internally, irq must stay low.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            rd(2'd2, d);
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL masked_irq k=%0d got=%0b exp=0", k, irq);
            end
            checks++;
            if (d !== 32'((k < 3) ? (3 - k) : 0)) begin
                errors++;
                $display("FAIL masked_count k=%0d got=%0d exp=%0d", k, d, (k < 3) ? (3 - k) : 0);
            end
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL masked_ctrl got=0x%08h exp=0x0", d);
        end
        // Pause at COUNT=7.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 4; k++) tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd7) begin
            errors++;
            $display("FAIL pause_reach7 got=%0d exp=7", d);
        end
        wr(2'd0, 32'h8);
        for (int k = 0; k < 20; k++) begin
            tick();
            rd(2'd2, d);
            checks++;
            if (d !== 32'd7 || irq !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold k=%0d got count=%0d irq=%0b exp count=7 irq=0", k, d, irq);
            end
        end
        $display("test_mask_pause done");
    endtask

    task automatic test_boundaries();
        logic [31:0] d;
        // PRESET=0 one-shot: irq after edge T+2.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL zero_preset_early got=%0b exp=0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL zero_preset_irq got=%0b exp=1", irq);
        end
        wr(2'd0, 32'h8);
        // PRESET write during CNT at COUNT=4.
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 3; k++) tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd4) begin
            errors++;
            $display("FAIL restart_reach4 got=%0d exp=4", d);
        end
        wr(2'd1, 32'd9);
        rd(2'd2, d);
        checks++;
        if (d !== 32'd4 || irq !== 1'b0) begin
            errors++;
            $display("FAIL restart_park got count=%0d irq=%0b exp count=4 irq=0", d, irq);
        end
        tick();
        tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd9) begin
            errors++;
            $display("FAIL restart_reload got=%0d exp=9", d);
        end
        tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd8) begin
            errors++;
            $display("FAIL restart_dec got=%0d exp=8", d);
        end
        // Reset while in INT.
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick();
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL int_before_rst got=%0b exp=1", irq);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_int_irq got=%0b exp=0", irq);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_in_int_ctrl got=0x%08h exp=0x0", d);
        end
        rd(2'd1, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_in_int_preset got=0x%08h exp=0x0", d);
        end
        $display("test_boundaries done");
    endtask

    task automatic test_bus();
        logic [31:0] d;
        wr(2'd1, 32'h12);
        wr(2'd2, 32'h55);
        rd(2'd2, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL bus_count_ro got=0x%08h exp=0x0", d);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL bus_ctrl_untouched got=0x%08h exp=0x0", d);
        end
        wr(2'd3, 32'hAA);
        rd(2'd1, d);
        checks++;
        if (d !== 32'h12) begin
            errors++;
            $display("FAIL bus_preset_untouched got=0x%08h exp=0x12", d);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL bus_reserved_read got=0x%08h exp=0x0", d);
        end
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, d);
        checks++;
        if (d !== 32'hF) begin
            errors++;
            $display("FAIL bus_ctrl_mask got=0x%08h exp=0xF", d);
        end
        $display("test_bus done");
    endtask

    initial begin
        rst  = 1'b1;
        we   = 1'b0;
        addr = 2'd0;
        din  = 32'd0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_mask_pause();
        test_boundaries();
        test_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
